// File: rtl/libnet_pkg.sv
// Shared libnet definitions: header field positions, FSM state encoding and
// the beat-select used when the transmit FSM leaves IDLE.
package libnet_pkg;

    localparam int DATA_W = 512;
    localparam int KEEP_W = 64;
    localparam int USER_W = 64;
    localparam int SEQ_W  = 32;

    localparam int CUR_SEQ_LSB_DEF = 344;
    localparam int CUR_SEQ_MSB_DEF = 375;
    localparam int ACK_FLAG_DEF    = 376;
    localparam int SYN_FLAG_DEF    = 377;
    localparam int ACK_SEQ_LSB_DEF = 378;
    localparam int ACK_SEQ_MSB_DEF = 409;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DATA_HDR = 2'd1,
        STREAM   = 2'd2,
        CTRL     = 2'd3
    } libnet_state_e;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_SYN  = 2'd1,
        SEL_DATA = 2'd2,
        SEL_ACK  = 2'd3
    } libnet_sel_e;

    // Sequence numbers wrap naturally at 32 bits.
    function automatic logic [SEQ_W-1:0] seq_add1(input logic [SEQ_W-1:0] s);
        return s + 32'd1;
    endfunction

endpackage

// File: rtl/libnet_hdr_build.sv
// Combinational header builder: overlays sequence, flags and (when ACK is set)
// the acknowledged sequence onto the static header template.
module libnet_hdr_build
    import libnet_pkg::*;
#(
    parameter int CURRENT_SEQ_LSB = CUR_SEQ_LSB_DEF,
    parameter int CURRENT_SEQ_MSB = CUR_SEQ_MSB_DEF,
    parameter int ACK_FLAG        = ACK_FLAG_DEF,
    parameter int SYN_FLAG        = SYN_FLAG_DEF,
    parameter int ACK_SEQ_LSB     = ACK_SEQ_LSB_DEF,
    parameter int ACK_SEQ_MSB     = ACK_SEQ_MSB_DEF
) (
    input  logic [DATA_W-1:0] hdr_base,
    input  logic [SEQ_W-1:0]  seq,
    input  logic              syn,
    input  logic              ack,
    input  logic [SEQ_W-1:0]  ack_seq,
    output logic [DATA_W-1:0] hdr
);

    // The ack field keeps the template contents unless an ack is carried.
    always_comb begin
        hdr = hdr_base;
        hdr[CURRENT_SEQ_MSB:CURRENT_SEQ_LSB] = seq;
        hdr[ACK_FLAG] = ack;
        hdr[SYN_FLAG] = syn;
        if (ack) begin
            hdr[ACK_SEQ_MSB:ACK_SEQ_LSB] = ack_seq;
        end
    end

endmodule

// File: rtl/tx_libnet_512.sv
// libnet transmit path: prefixes app packets with a sequenced header and emits
// SYN/ACK control beats. Define TX_LIBNET_ACK_PIGGYBACK_EN to carry acks in data headers.
module tx_libnet_512
    import libnet_pkg::*;
#(
    parameter int CURRENT_SEQ_LSB = CUR_SEQ_LSB_DEF,
    parameter int CURRENT_SEQ_MSB = CUR_SEQ_MSB_DEF,
    parameter int ACK_FLAG        = ACK_FLAG_DEF,
    parameter int SYN_FLAG        = SYN_FLAG_DEF,
    parameter int ACK_SEQ_LSB     = ACK_SEQ_LSB_DEF,
    parameter int ACK_SEQ_MSB     = ACK_SEQ_MSB_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic [USER_W-1:0] rx_tuser,
    input  logic              rx_tvalid,
    input  logic              rx_tlast,
    output logic              rx_tready,
    output logic [DATA_W-1:0] tx_tdata,
    output logic [KEEP_W-1:0] tx_tkeep,
    output logic [USER_W-1:0] tx_tuser,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready,
    input  logic [DATA_W-1:0] hdr_base,
    input  logic [SEQ_W-1:0]  ack_seq,
    input  logic              ack_valid,
    input  logic              syn_req,
    input  logic [SEQ_W-1:0]  syn_seq,
    output logic              syn_done,
    output logic [SEQ_W-1:0]  seq_next,
    output logic [SEQ_W-1:0]  tx_pkt_cnt
);

    libnet_state_e     state;
    libnet_sel_e       idle_sel;
    logic              can_load;
    logic              syn_take;
    logic              ack_pend;
    logic              ack_dirty;
    logic [SEQ_W-1:0]  ack_val;
    logic              syn_pend;
    logic [SEQ_W-1:0]  syn_val;
    logic [SEQ_W-1:0]  hb_seq;
    logic              hb_syn;
    logic              hb_ack;
    logic [DATA_W-1:0] hdr_word;

    assign can_load  = !tx_tvalid || tx_tready;
    assign rx_tready = (state == STREAM) && can_load;
    assign syn_take  = (state == IDLE) && can_load && (idle_sel == SEL_SYN);

    // Decide which beat IDLE would launch and set up the header overlay for it.
    always_comb begin
        idle_sel = SEL_NONE;
        hb_seq   = seq_next;
        hb_syn   = 1'b0;
        hb_ack   = 1'b0;
        if (syn_req || syn_pend) begin
            idle_sel = SEL_SYN;
        end else if (rx_tvalid) begin
            idle_sel = SEL_DATA;
        end else if (ack_pend) begin
            idle_sel = SEL_ACK;
        end
        case (idle_sel)
            SEL_SYN: begin
                hb_seq = syn_req ? syn_seq : syn_val;
                hb_syn = 1'b1;
            end
`ifdef TX_LIBNET_ACK_PIGGYBACK_EN
            SEL_DATA: hb_ack = ack_pend;
`endif
            SEL_ACK:  hb_ack = 1'b1;
            default: ;
        endcase
    end

    libnet_hdr_build #(
        .CURRENT_SEQ_LSB(CURRENT_SEQ_LSB),
        .CURRENT_SEQ_MSB(CURRENT_SEQ_MSB),
        .ACK_FLAG       (ACK_FLAG),
        .SYN_FLAG       (SYN_FLAG),
        .ACK_SEQ_LSB    (ACK_SEQ_LSB),
        .ACK_SEQ_MSB    (ACK_SEQ_MSB)
    ) u_hdr (
        .hdr_base(hdr_base),
        .seq     (hb_seq),
        .syn     (hb_syn),
        .ack     (hb_ack),
        .ack_seq (ack_val),
        .hdr     (hdr_word)
    );

    // ack_dirty marks an ack that arrived after the carrying beat was built,
    // so accepting that beat must not drop the newer value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx_tdata   <= '0;
            tx_tkeep   <= '0;
            tx_tuser   <= '0;
            tx_tvalid  <= 1'b0;
            tx_tlast   <= 1'b0;
            syn_done   <= 1'b0;
            seq_next   <= '0;
            tx_pkt_cnt <= '0;
            ack_pend   <= 1'b0;
            ack_dirty  <= 1'b0;
            ack_val    <= '0;
            syn_pend   <= 1'b0;
            syn_val    <= '0;
        end else begin
            syn_done <= 1'b0;
            if (tx_tvalid && tx_tready) begin
                tx_tvalid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (can_load && idle_sel != SEL_NONE) begin
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= hdr_word;
                        tx_tkeep  <= '1;
                        tx_tuser  <= '0;
                        tx_tlast  <= (idle_sel != SEL_DATA);
                        ack_dirty <= 1'b0;
                        if (idle_sel == SEL_SYN) begin
                            syn_pend <= 1'b0;
                        end
                        state <= (idle_sel == SEL_DATA) ? DATA_HDR : CTRL;
                    end
                end
                DATA_HDR: begin
                    if (tx_tready) begin
                        seq_next   <= seq_add1(seq_next);
                        tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
                        if (tx_tdata[ACK_FLAG] && !ack_dirty) begin
                            ack_pend <= 1'b0;
                        end
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (rx_tvalid && rx_tready) begin
                        tx_tvalid <= 1'b1;
                        tx_tdata  <= rx_tdata;
                        tx_tkeep  <= rx_tkeep;
                        tx_tuser  <= rx_tuser;
                        tx_tlast  <= rx_tlast;
                        if (rx_tlast) begin
                            state <= IDLE;
                        end
                    end
                end
                CTRL: begin
                    if (tx_tready) begin
                        tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
                        if (tx_tdata[SYN_FLAG]) begin
                            seq_next <= tx_tdata[CURRENT_SEQ_MSB:CURRENT_SEQ_LSB];
                            syn_done <= 1'b1;
                        end
                        if (tx_tdata[ACK_FLAG] && !ack_dirty) begin
                            ack_pend <= 1'b0;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (syn_req && !syn_take) begin
                syn_pend <= 1'b1;
                syn_val  <= syn_seq;
            end
            if (ack_valid) begin
                ack_val   <= ack_seq;
                ack_pend  <= 1'b1;
                ack_dirty <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_libnet_512.sv
// Directed self-checking bench for tx_libnet_512; expected beats come from a
// small header/payload model and tracked sequence/packet counters.
module tb_tx_libnet_512;

    localparam int SEQ_LSB  = 344;
    localparam int SEQ_MSB  = 375;
    localparam int ACK_F    = 376;
    localparam int SYN_F    = 377;
    localparam int ACKS_LSB = 378;
    localparam int ACKS_MSB = 409;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic [63:0]  u;
        logic         l;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [511:0] rx_tdata;
    logic [63:0]  rx_tkeep;
    logic [63:0]  rx_tuser;
    logic         rx_tvalid;
    logic         rx_tlast;
    logic         rx_tready;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tkeep;
    logic [63:0]  tx_tuser;
    logic         tx_tvalid;
    logic         tx_tlast;
    logic         tx_tready;
    logic [511:0] hdr_base;
    logic [31:0]  ack_seq;
    logic         ack_valid;
    logic         syn_req;
    logic [31:0]  syn_seq;
    logic         syn_done;
    logic [31:0]  seq_next;
    logic [31:0]  tx_pkt_cnt;

    int    total;
    int    bad;
    int    syn_done_cnt;
    logic  abort;
    logic [31:0] m_seq;
    logic [31:0] m_cnt;
    beat_t mon_q[$];
    beat_t exp_q[$];

    tx_libnet_512 dut (
        .clk(clk), .reset(reset),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser),
        .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .hdr_base(hdr_base), .ack_seq(ack_seq), .ack_valid(ack_valid),
        .syn_req(syn_req), .syn_seq(syn_seq), .syn_done(syn_done),
        .seq_next(seq_next), .tx_pkt_cnt(tx_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record each beat that will be accepted at the coming rising edge.
    always begin
        @(negedge clk);
        #2;
        if (!reset && tx_tvalid && tx_tready) begin
            mon_q.push_back({tx_tdata, tx_tkeep, tx_tuser, tx_tlast});
        end
        if (syn_done) begin
            syn_done_cnt++;
        end
    end

    function automatic beat_t pay(input int id, input int b, input int n);
        beat_t r;
        logic [31:0] w;
        w = {id[15:0], b[15:0]};
        r.d = {16{w}};
        r.k = (b == n - 1) ? 64'h0000_0000_0000_FFFF : '1;
        r.u = {32'(id), 32'(b)};
        r.l = (b == n - 1);
        return r;
    endfunction

    function automatic beat_t hdr(input logic [31:0] seq, input logic syn, input logic ack,
                                  input logic [31:0] ackv, input logic last);
        beat_t r;
        r.d = hdr_base;
        r.d[SEQ_MSB:SEQ_LSB] = seq;
        r.d[ACK_F] = ack;
        r.d[SYN_F] = syn;
        if (ack) r.d[ACKS_MSB:ACKS_LSB] = ackv;
        r.k = '1;
        r.u = '0;
        r.l = last;
        return r;
    endfunction

    task automatic send_pkt(input int id, input int n);
        beat_t b;
        logic  acc;
        int    waitc;
        for (int i = 0; i < n; i++) begin
            acc = 1'b0;
            waitc = 0;
            @(negedge clk);
            b = pay(id, i, n);
            rx_tvalid = 1'b1;
            rx_tdata  = b.d;
            rx_tkeep  = b.k;
            rx_tuser  = b.u;
            rx_tlast  = b.l;
            while (!acc) begin
                #1;
                if (abort) begin
                    rx_tvalid = 1'b0;
                    return;
                end
                acc = rx_tready;
                @(posedge clk);
                if (!acc) begin
                    waitc++;
                    if (waitc > 300) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL send_pkt_timeout id=%0d beat=%0d got no rx_tready, required within 300 cycles", id, i);
                        rx_tvalid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
        end
        @(negedge clk);
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic wait_q(input int n);
        for (int c = 0; c < 400; c++) begin
            if (mon_q.size() >= n) break;
            @(negedge clk);
            #3;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (tx_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_tvalid got=%b want=0", tx_tvalid); end
        total++; if (tx_tlast !== 1'b0) begin bad++; $display("[TB] FAIL reset_tlast got=%b want=0", tx_tlast); end
        total++; if (tx_tdata !== '0) begin bad++; $display("[TB] FAIL reset_tdata got=%h want=0", tx_tdata); end
        total++; if ({tx_tkeep, tx_tuser} !== '0) begin bad++; $display("[TB] FAIL reset_keep_user got=%h want=0", {tx_tkeep, tx_tuser}); end
        total++; if (syn_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_syn_done got=%b want=0", syn_done); end
        total++; if (seq_next !== 32'd0) begin bad++; $display("[TB] FAIL reset_seq_next got=%h want=0", seq_next); end
        total++; if (tx_pkt_cnt !== 32'd0) begin bad++; $display("[TB] FAIL reset_pkt_cnt got=%h want=0", tx_pkt_cnt); end
        total++; if (rx_tready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rx_tready got=%b want=0", rx_tready); end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (tx_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset_tvalid got=%b want=0", tx_tvalid); end
        m_seq = 32'd0;
        m_cnt = 32'd0;
    endtask

    task automatic test_basic_packet;
        int q0;
        q0 = mon_q.size();
        exp_q = {};
        exp_q.push_back(hdr(m_seq, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 3; i++) exp_q.push_back(pay(1, i, 3));
        m_seq = m_seq + 32'd1;
        m_cnt = m_cnt + 32'd1;
        send_pkt(1, 3);
        wait_q(q0 + 4);
        repeat (6) @(negedge clk);
        total++; if (mon_q.size() != q0 + 4) begin bad++; $display("[TB] FAIL basic_beat_count got=%0d want=%0d", mon_q.size() - q0, 4); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL basic_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
        total++; if (seq_next !== m_seq) begin bad++; $display("[TB] FAIL basic_seq_next got=%h want=%h", seq_next, m_seq); end
        total++; if (tx_pkt_cnt !== m_cnt) begin bad++; $display("[TB] FAIL basic_pkt_cnt got=%h want=%h", tx_pkt_cnt, m_cnt); end
    endtask

    // SYN requested mid-packet: packet completes first, then the SYN beat.
    task automatic test_syn;
        int q0;
        int s0;
        q0 = mon_q.size();
        s0 = syn_done_cnt;
        exp_q = {};
        exp_q.push_back(hdr(m_seq, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 2; i++) exp_q.push_back(pay(2, i, 2));
        exp_q.push_back(hdr(32'h100, 1'b1, 1'b0, 32'd0, 1'b1));
        exp_q.push_back(hdr(32'h100, 1'b0, 1'b0, 32'd0, 1'b0));
        exp_q.push_back(pay(3, 0, 1));
        fork
            send_pkt(2, 2);
            begin
                wait_q(q0 + 1);
                @(negedge clk);
                syn_req = 1'b1;
                syn_seq = 32'h100;
                @(negedge clk);
                syn_req = 1'b0;
                syn_seq = 32'hDEAD_BEEF;
            end
        join
        wait_q(q0 + 4);
        repeat (4) @(negedge clk);
        total++; if (syn_done_cnt - s0 != 1) begin bad++; $display("[TB] FAIL syn_done_pulses got=%0d want=1", syn_done_cnt - s0); end
        total++; if (seq_next !== 32'h100) begin bad++; $display("[TB] FAIL syn_seq_next got=%h want=00000100", seq_next); end
        send_pkt(3, 1);
        wait_q(q0 + 6);
        repeat (6) @(negedge clk);
        m_seq = 32'h101;
        m_cnt = m_cnt + 32'd3;
        total++; if (mon_q.size() != q0 + 6) begin bad++; $display("[TB] FAIL syn_beat_count got=%0d want=6", mon_q.size() - q0); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL syn_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
        total++; if (seq_next !== m_seq) begin bad++; $display("[TB] FAIL syn_after_pkt_seq got=%h want=%h", seq_next, m_seq); end
        total++; if (tx_pkt_cnt !== m_cnt) begin bad++; $display("[TB] FAIL syn_pkt_cnt got=%h want=%h", tx_pkt_cnt, m_cnt); end
    endtask

    task automatic test_wrap;
        int q0;
        q0 = mon_q.size();
        exp_q = {};
        exp_q.push_back(hdr(32'hFFFF_FFFF, 1'b1, 1'b0, 32'd0, 1'b1));
        exp_q.push_back(hdr(32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 2; i++) exp_q.push_back(pay(4, i, 2));
        @(negedge clk);
        syn_req = 1'b1;
        syn_seq = 32'hFFFF_FFFF;
        @(negedge clk);
        syn_req = 1'b0;
        wait_q(q0 + 1);
        repeat (3) @(negedge clk);
        send_pkt(4, 2);
        wait_q(q0 + 4);
        repeat (6) @(negedge clk);
        m_seq = 32'd0;
        m_cnt = m_cnt + 32'd2;
        total++; if (mon_q.size() != q0 + 4) begin bad++; $display("[TB] FAIL wrap_beat_count got=%0d want=4", mon_q.size() - q0); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL wrap_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
        total++; if (seq_next !== m_seq) begin bad++; $display("[TB] FAIL wrap_seq_next got=%h want=%h", seq_next, m_seq); end
        total++; if (tx_pkt_cnt !== m_cnt) begin bad++; $display("[TB] FAIL wrap_pkt_cnt got=%h want=%h", tx_pkt_cnt, m_cnt); end
    endtask

    task automatic test_backpressure;
        int q0;
        logic [511:0] snap;
        q0 = mon_q.size();
        exp_q = {};
        exp_q.push_back(hdr(m_seq, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 4; i++) exp_q.push_back(pay(5, i, 4));
        fork
            send_pkt(5, 4);
            begin
                wait_q(q0 + 2);
                @(negedge clk);
                tx_tready = 1'b0;
                snap = tx_tdata;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    total++; if (tx_tvalid !== 1'b1) begin bad++; $display("[TB] FAIL stall_tvalid c=%0d got=%b want=1", c, tx_tvalid); end
                    total++; if (tx_tdata !== snap) begin bad++; $display("[TB] FAIL stall_tdata c=%0d got=%h want=%h", c, tx_tdata, snap); end
                    total++; if (rx_tready !== 1'b0) begin bad++; $display("[TB] FAIL stall_rx_tready c=%0d got=%b want=0", c, rx_tready); end
                end
                tx_tready = 1'b1;
            end
        join
        wait_q(q0 + 5);
        repeat (6) @(negedge clk);
        m_seq = m_seq + 32'd1;
        m_cnt = m_cnt + 32'd1;
        total++; if (mon_q.size() != q0 + 5) begin bad++; $display("[TB] FAIL bp_beat_count got=%0d want=5", mon_q.size() - q0); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL bp_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
    endtask

    // Acks 5 then 7 arrive while the output is stalled; only 7 must go out.
    task automatic test_ack_coalesce;
        int q0;
        int n;
        q0 = mon_q.size();
        exp_q = {};
        exp_q.push_back(hdr(m_seq, 1'b0, 1'b0, 32'd0, 1'b0));
        for (int i = 0; i < 2; i++) exp_q.push_back(pay(6, i, 2));
`ifdef TX_LIBNET_ACK_PIGGYBACK_EN
        exp_q.push_back(hdr(m_seq + 32'd1, 1'b0, 1'b1, 32'd7, 1'b0));
        exp_q.push_back(pay(7, 0, 1));
        m_cnt = m_cnt + 32'd2;
`else
        exp_q.push_back(hdr(m_seq + 32'd1, 1'b0, 1'b0, 32'd0, 1'b0));
        exp_q.push_back(pay(7, 0, 1));
        exp_q.push_back(hdr(m_seq + 32'd2, 1'b0, 1'b1, 32'd7, 1'b1));
        m_cnt = m_cnt + 32'd3;
`endif
        m_seq = m_seq + 32'd2;
        n = exp_q.size();
        fork
            send_pkt(6, 2);
            begin
                wait_q(q0 + 2);
                @(negedge clk);
                tx_tready = 1'b0;
            end
        join
        @(negedge clk);
        ack_valid = 1'b1;
        ack_seq   = 32'd5;
        @(negedge clk);
        ack_seq   = 32'd7;
        @(negedge clk);
        ack_valid = 1'b0;
        ack_seq   = 32'd0;
        fork
            send_pkt(7, 1);
            begin
                repeat (3) @(negedge clk);
                tx_tready = 1'b1;
            end
        join
        wait_q(q0 + n);
        repeat (8) @(negedge clk);
        total++; if (mon_q.size() != q0 + n) begin bad++; $display("[TB] FAIL ack_beat_count got=%0d want=%0d", mon_q.size() - q0, n); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL ack_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
        total++; if (tx_pkt_cnt !== m_cnt) begin bad++; $display("[TB] FAIL ack_pkt_cnt got=%h want=%h", tx_pkt_cnt, m_cnt); end
        total++; if (seq_next !== m_seq) begin bad++; $display("[TB] FAIL ack_seq_next got=%h want=%h", seq_next, m_seq); end
    endtask

    task automatic test_reset_mid;
        int q0;
        q0 = mon_q.size();
        fork
            send_pkt(8, 4);
            begin
                wait_q(q0 + 2);
                @(negedge clk);
                reset = 1'b1;
                abort = 1'b1;
            end
        join
        @(negedge clk);
        total++; if (tx_tvalid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_tvalid got=%b want=0", tx_tvalid); end
        total++; if (seq_next !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_seq_next got=%h want=0", seq_next); end
        total++; if (tx_pkt_cnt !== 32'd0) begin bad++; $display("[TB] FAIL rstmid_pkt_cnt got=%h want=0", tx_pkt_cnt); end
        reset = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (rx_tready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_idle_rx_tready got=%b want=0", rx_tready); end
        total++; if (mon_q.size() != q0 + 2) begin bad++; $display("[TB] FAIL rstmid_beats got=%0d want=2", mon_q.size() - q0); end
        q0 = mon_q.size();
        exp_q = {};
        exp_q.push_back(hdr(32'd0, 1'b0, 1'b0, 32'd0, 1'b0));
        exp_q.push_back(pay(9, 0, 1));
        send_pkt(9, 1);
        wait_q(q0 + 2);
        repeat (6) @(negedge clk);
        total++; if (mon_q.size() != q0 + 2) begin bad++; $display("[TB] FAIL restart_beat_count got=%0d want=2", mon_q.size() - q0); end
        for (int i = 0; i < exp_q.size() && q0 + i < mon_q.size(); i++) begin
            total++;
            if (mon_q[q0 + i] !== exp_q[i]) begin bad++; $display("[TB] FAIL restart_beat%0d got=%h want=%h", i, mon_q[q0 + i], exp_q[i]); end
        end
        total++; if (seq_next !== 32'd1) begin bad++; $display("[TB] FAIL restart_seq_next got=%h want=1", seq_next); end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        syn_done_cnt = 0;
        abort        = 1'b0;
        m_seq        = '0;
        m_cnt        = '0;
        reset        = 1'b1;
        rx_tdata     = '0;
        rx_tkeep     = '0;
        rx_tuser     = '0;
        rx_tvalid    = 1'b0;
        rx_tlast     = 1'b0;
        tx_tready    = 1'b1;
        hdr_base     = {8{64'hA5C3_0123_4567_89AB}};
        ack_seq      = '0;
        ack_valid    = 1'b0;
        syn_req      = 1'b0;
        syn_seq      = '0;
        test_reset;
        test_basic_packet;
        test_syn;
        test_wrap;
        test_backpressure;
        test_ack_coalesce;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog simulation time exceeded, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/tx_libnet_512.md
TX_LIBNET_512 -- requirements
Module: tx_libnet_512

Interface
REQ-001 SHALL have parameter CURRENT_SEQ_LSB, default 344, LSB of sequence field in header beat.
REQ-002 SHALL have parameter CURRENT_SEQ_MSB, default 375, MSB of sequence field.
REQ-003 SHALL have parameter ACK_FLAG, default 376, ACK flag bit.
REQ-004 SHALL have parameter SYN_FLAG, default 377, SYN flag bit.
REQ-005 SHALL have parameters ACK_SEQ_LSB, default 378, and ACK_SEQ_MSB, default 409, bounding the acknowledged-sequence field.
REQ-006 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_tdata/rx_tkeep/rx_tuser  in  512/64/64  app payload beats.
- rx_tvalid/rx_tlast  in  1/1  app beat valid / last beat.
- rx_tready  out  1  app beat accepted.
- tx_tdata/tx_tkeep/tx_tuser  out  512/64/64  frames to sysnet.
- tx_tvalid/tx_tlast  out  1/1  frame beat valid / last beat.
- tx_tready  in  1  sysnet accepts beat.
- hdr_base  in  512  static header template (MAC/IP/UDP).
- ack_seq/ack_valid  in  32/1  ack from local receive side.
- syn_req/syn_seq  in  1/32  host-requested resync and its sequence value.
- syn_done  out  1  one-cycle pulse when SYN beat is accepted.
- seq_next  out  32  sequence number the next data packet will carry.
- tx_pkt_cnt  out  32  count of accepted header beats.

Function
REQ-007 SHALL register all tx_* outputs; while tx_tvalid=1 and tx_tready=0, tx_* SHALL hold stable.
REQ-008 SHALL drive rx_tready=1 only in STREAM when (!tx_tvalid || tx_tready); combinational.
REQ-009 SHALL use FSM states IDLE, DATA_HDR, STREAM, CTRL.
REQ-010 IDLE priority: syn_req -> CTRL(SYN); else rx_tvalid -> DATA_HDR; else ack pending -> CTRL(ACK); else stay.
REQ-011 DATA_HDR SHALL emit one beat: hdr_base with seq field=seq_next, SYN=0, tkeep all ones, tuser 0, tlast 0; on accept -> STREAM and seq_next+1, wrapping 0xFFFFFFFF->0.
REQ-012 STREAM SHALL pass app beats unmodified with 1-cycle latency; on accepted rx_tlast beat -> IDLE.
REQ-013 CTRL(SYN) SHALL emit single beat with SYN=1, seq field=syn_seq, tlast=1; on accept set seq_next=syn_seq, pulse syn_done, -> IDLE.
REQ-014 CTRL(ACK) SHALL emit single beat with ACK=1, ack field=pending ack, seq field=seq_next (not incremented), tlast=1; on accept clear pending, -> IDLE.
REQ-015 ack_valid SHALL latch ack_seq into a single pending register; newer ack overwrites older (coalescing); an ack_valid arriving in the cycle pending is consumed SHALL remain pending.
REQ-016 syn_req asserted mid-packet SHALL be latched and serviced at next IDLE; data packet never truncated.
REQ-017 tx_pkt_cnt SHALL increment on every accepted header/control beat, wrapping at 32 bits.

Reset
REQ-018 On reset: tx_tvalid=0, tx_tlast=0, tx_tdata/tkeep/tuser=0, syn_done=0, seq_next=0, tx_pkt_cnt=0, ack pending cleared, syn latch cleared, state IDLE.
REQ-019 Reset mid-packet SHALL abort immediately; no further beats of that packet emitted; app must restart packet.

Configuration
REQ-020 With TX_LIBNET_ACK_PIGGYBACK_EN defined, DATA_HDR SHALL set ACK=1 and ack field=pending ack when pending, clearing it on accept; without it, DATA_HDR ACK=0 and acks go only via CTRL(ACK).

Structure
REQ-021 Field-position constants and state encoding SHALL live in shared package libnet_pkg, used also by rx_libnet_512.
REQ-022 Header construction (hdr_base plus seq/flag/ack overlay) SHALL be sub-module libnet_hdr_build, combinational.

Verification
REQ-023 Reset, 3-beat app packet -> header seq=0, then 3 payload beats, seq_next=1, tx_pkt_cnt=1.
REQ-024 syn_req with syn_seq=0x100 -> SYN beat seq=0x100, tlast=1, syn_done pulse; next data header seq=0x100.
REQ-025 seq_next=0xFFFFFFFF, send packet -> header seq=0xFFFFFFFF, seq_next=0.
REQ-026 tx_tready low 5 cycles mid-stream -> tx_* stable, rx_tready=0, no beat lost or duplicated.
REQ-027 ack_valid 5 then 7 while idle-blocked -> one ACK beat with ack field=7 (macro off); macro on with data pending -> data header ACK=1, ack field=7, no CTRL beat.
REQ-028 reset asserted at beat 2 of 4 -> tx_tvalid=0 next edge, state IDLE, seq_next=0.
